// File: rtl/snn_spi_config_loader.sv
// SPI mode-0 slave, oversampled on clk, that loads the configuration register file
// (weights, delays, threshold, decay, refractory period, control) feeding the delayed-SNN top.
//
// state | meaning
// IDLE  | no transaction; waiting for a falling chip select
// CMD   | shifting in the command byte {rw, addr[6:0]}
// DATA  | streaming data bytes (write into regs or read out on miso), addr auto-increments
module snn_spi_config_loader #(
  parameter int WEIGHT_BYTES = 80,
  parameter int DELAY_BYTES  = 40,
  parameter int ADDR_W       = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sclk,
  input  logic                      cs_n,
  input  logic                      mosi,
  output logic                      miso,
  output logic [WEIGHT_BYTES*8-1:0] weights,
  output logic [DELAY_BYTES*8-1:0]  delays,
  output logic [7:0]                threshold,
  output logic [7:0]                decay,
  output logic [7:0]                refractory_period,
  output logic                      enable,
  output logic                      busy
);

  localparam int A_THR  = WEIGHT_BYTES + DELAY_BYTES;
  localparam int A_DEC  = A_THR + 1;
  localparam int A_REF  = A_THR + 2;
  localparam int A_CTRL = A_THR + 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state, state_n;

  logic [1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_d, cs_d;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [3:0]        bits_left;
  logic [6:0]        shift_q;
  logic [7:0]        byte_in;
  logic              last_bit;
  logic [ADDR_W-1:0] addr_q;
  logic              is_write;
  logic [7:0]        tx_q;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [7:0]        ctrl_q;

  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_byte;

  logic cmd_done, data_done, shift_en, clr_bits, tx_shift;

  // cs_n chain resets low so a chip select held through reset never looks like a new falling edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      cs_sync   <= {cs_sync[0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_d    <= sclk_sync[1];
      cs_d      <= cs_sync[1];
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;
  assign cs_rise   = cs_sync[1] & ~cs_d;
  assign cs_fall   = ~cs_sync[1] & cs_d;

  assign byte_in  = {shift_q, mosi_sync[1]};
  assign last_bit = (bits_left == 4'd1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cmd_done  = 1'b0;
    data_done = 1'b0;
    shift_en  = 1'b0;
    clr_bits  = 1'b0;
    tx_shift  = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_n  = CMD;
          clr_bits = 1'b1;
        end
      end
      CMD: begin
        if (cs_rise) begin
          state_n = IDLE;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
          if (last_bit) begin
            cmd_done = 1'b1;
            state_n  = DATA;
          end
        end
      end
      DATA: begin
        if (cs_rise) begin
          state_n = IDLE;
        end else begin
          if (sclk_rise) begin
            shift_en  = 1'b1;
            data_done = last_bit;
          end
          if (sclk_fall && !is_write) tx_shift = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Next read byte: the command's address while in CMD, otherwise the following address
  assign rd_addr = (state == CMD) ? byte_in[6:0] : addr_q + ADDR_W'(1);

  always_comb begin
    rd_byte = '0;
    for (int k = 0; k < WEIGHT_BYTES; k++)
      if (rd_addr == ADDR_W'(k)) rd_byte = weights[8*k +: 8];
    for (int k = 0; k < DELAY_BYTES; k++)
      if (rd_addr == ADDR_W'(WEIGHT_BYTES + k)) rd_byte = delays[8*k +: 8];
    if (rd_addr == ADDR_W'(A_THR))  rd_byte = threshold;
    if (rd_addr == ADDR_W'(A_DEC))  rd_byte = decay;
    if (rd_addr == ADDR_W'(A_REF))  rd_byte = refractory_period;
    if (rd_addr == ADDR_W'(A_CTRL)) rd_byte = ctrl_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bits_left <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      is_write  <= 1'b0;
      tx_q      <= '0;
      miso      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_en <= 1'b0;
      if (clr_bits) begin
        bits_left <= 4'd8;
        shift_q   <= '0;
      end else if (shift_en) begin
        shift_q   <= byte_in[6:0];
        bits_left <= last_bit ? 4'd8 : bits_left - 4'd1;
      end

      if (cmd_done) begin
        is_write <= byte_in[7];
        addr_q   <= byte_in[6:0];
        tx_q     <= rd_byte;
      end

      // Completed data byte: queue the write for the next cycle, or fetch the next read byte
      if (data_done) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (is_write) begin
          wr_en   <= 1'b1;
          wr_addr <= addr_q;
          wr_data <= byte_in;
        end else begin
          tx_q <= rd_byte;
        end
      end

      if (state != DATA || cs_sync[1]) begin
        miso <= 1'b0;
      end else if (tx_shift) begin
        miso <= tx_q[7];
        tx_q <= {tx_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      weights           <= '0;
      delays            <= '0;
      threshold         <= 8'h10;
      decay             <= 8'h01;
      refractory_period <= 8'h02;
      ctrl_q            <= 8'h00;
    end else if (wr_en) begin
      for (int k = 0; k < WEIGHT_BYTES; k++)
        if (wr_addr == ADDR_W'(k)) weights[8*k +: 8] <= wr_data;
      for (int k = 0; k < DELAY_BYTES; k++)
        if (wr_addr == ADDR_W'(WEIGHT_BYTES + k)) delays[8*k +: 8] <= wr_data;
      if (wr_addr == ADDR_W'(A_THR))  threshold         <= wr_data;
      if (wr_addr == ADDR_W'(A_DEC))  decay             <= wr_data;
      if (wr_addr == ADDR_W'(A_REF))  refractory_period <= wr_data;
      if (wr_addr == ADDR_W'(A_CTRL)) ctrl_q            <= wr_data;
    end
  end

  // Network only runs with chip select released, so it never sees half-written config
  always_ff @(posedge clk) begin
    if (reset) begin
      enable <= 1'b0;
      busy   <= 1'b0;
    end else begin
      enable <= ctrl_q[0] & cs_sync[1];
      busy   <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_snn_spi_config_loader.sv
// Directed bench for snn_spi_config_loader: SPI write/read transactions against a byte model
// of the register map, with read bytes checked through an expected-value queue.
module tb_snn_spi_config_loader;

  localparam int HALF = 8;

  logic         clk = 1'b0;
  logic         reset, sclk, cs_n, mosi;
  logic         miso;
  logic [639:0] weights;
  logic [319:0] delays;
  logic [7:0]   threshold, decay, refractory_period;
  logic         enable, busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mdl [128];
  logic [7:0] sb_q [$];
  logic [6:0] ptr;
  logic [7:0] rx;

  snn_spi_config_loader dut (
    .clk               (clk),
    .reset             (reset),
    .sclk              (sclk),
    .cs_n              (cs_n),
    .mosi              (mosi),
    .miso              (miso),
    .weights           (weights),
    .delays            (delays),
    .threshold         (threshold),
    .decay             (decay),
    .refractory_period (refractory_period),
    .enable            (enable),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic init_model();
    for (int i = 0; i < 128; i++) mdl[i] = 8'h00;
    mdl[120] = 8'h10;
    mdl[121] = 8'h01;
    mdl[122] = 8'h02;
  endtask

  // Shift nbits of tx MSB first; miso captured at each rising sclk edge
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      wait_clk(HALF);
      r = {r[6:0], miso};
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_start();
    cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic spi_end();
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic cmd(input logic wr, input logic [6:0] a);
    logic [7:0] r;
    spi_bits({wr, a}, 8, r);
    ptr = a;
  endtask

  task automatic wr_data(input logic [7:0] d);
    logic [7:0] r;
    spi_bits(d, 8, r);
    if (ptr < 7'd124) mdl[ptr] = d;
    ptr = ptr + 7'd1;
  endtask

  task automatic rd_data(input string tag);
    logic [7:0] r, e;
    sb_q.push_back(mdl[ptr]);
    ptr = ptr + 7'd1;
    spi_bits(8'h00, 8, r);
    if (sb_q.size() == 0) begin
      e = 8'hxx;
    end else begin
      e = sb_q.pop_front();
    end
    check(tag, r, e);
  endtask

  initial begin
    reset = 1'b1;
    sclk  = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    ptr   = '0;
    init_model();
    wait_clk(2);
    reset = 1'b0;
    wait_clk(4);

    check("rst_threshold", threshold, 8'h10);
    check("rst_decay", decay, 8'h01);
    check("rst_refractory", refractory_period, 8'h02);
    check("rst_weights_zero", 8'(|weights), 8'h00);
    check("rst_delays_zero", 8'(|delays), 8'h00);
    check("rst_enable", 8'(enable), 8'h00);
    check("rst_miso", 8'(miso), 8'h00);
    check("rst_busy", 8'(busy), 8'h00);

    // Burst write of all weights, one extra byte spills into delays
    spi_start();
    check("busy_in_txn", 8'(busy), 8'h01);
    cmd(1'b1, 7'd0);
    for (int i = 0; i < 80; i++) wr_data(8'(i));
    wr_data(8'hAB);
    spi_end();
    check("burst_w0", weights[7:0], mdl[0]);
    check("burst_w1", weights[15:8], 8'h01);
    check("burst_w79", weights[639:632], 8'h4F);
    check("burst_d0", delays[7:0], 8'hAB);
    check("burst_busy_after", 8'(busy), 8'h00);

    // Threshold write, then read back a run across the scalar registers
    spi_start();
    cmd(1'b1, 7'd120);
    wr_data(8'h5A);
    spi_end();
    check("thr_written", threshold, 8'h5A);
    spi_start();
    cmd(1'b0, 7'd120);
    rd_data("rd_thr");
    rd_data("rd_decay");
    rd_data("rd_refr");
    rd_data("rd_ctrl");
    rd_data("rd_rsv124");
    spi_end();
    check("miso_idle", 8'(miso), 8'h00);

    // Read across the address wrap 127 -> 0 -> 1
    spi_start();
    cmd(1'b0, 7'd127);
    rd_data("rd_127");
    rd_data("rd_wrap0");
    rd_data("rd_wrap1");
    rd_data("rd_wrap2");
    spi_end();

    // Abort after 5 data bits: no change, next transaction decodes normally
    spi_start();
    cmd(1'b1, 7'd1);
    spi_bits(8'hFF, 5, rx);
    spi_end();
    check("abort_w1", weights[15:8], 8'h01);
    spi_start();
    cmd(1'b1, 7'd1);
    wr_data(8'h33);
    spi_end();
    check("after_abort_w1", weights[15:8], 8'h33);

    // Enable gating and reserved address behaviour
    spi_start();
    cmd(1'b1, 7'd123);
    wr_data(8'h01);
    spi_end();
    check("enable_on", 8'(enable), 8'h01);
    spi_start();
    check("enable_gated", 8'(enable), 8'h00);
    cmd(1'b1, 7'd125);
    wr_data(8'hEE);
    spi_end();
    check("enable_back", 8'(enable), 8'h01);
    spi_start();
    cmd(1'b0, 7'd125);
    rd_data("rd_rsv125");
    check("enable_gated_rd", 8'(enable), 8'h00);
    spi_end();
    spi_start();
    cmd(1'b0, 7'd0);
    rd_data("rd_w0");
    rd_data("rd_w1_after_abort");
    spi_end();

    // Reset in the middle of a data byte; the held transaction stays dead
    spi_start();
    cmd(1'b1, 7'd2);
    spi_bits(8'hFF, 4, rx);
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(4);
    init_model();
    check("midrst_threshold", threshold, 8'h10);
    check("midrst_weights_zero", 8'(|weights), 8'h00);
    check("midrst_delays_zero", 8'(|delays), 8'h00);
    check("midrst_busy", 8'(busy), 8'h00);
    check("midrst_enable", 8'(enable), 8'h00);
    spi_bits(8'hFF, 4, rx);
    spi_bits(8'h55, 8, rx);
    check("dead_busy", 8'(busy), 8'h00);
    check("dead_weights_zero", 8'(|weights), 8'h00);
    spi_end();
    check("midrst_enable_after", 8'(enable), 8'h00);
    spi_start();
    cmd(1'b1, 7'd2);
    wr_data(8'h77);
    spi_end();
    check("recover_w2", weights[23:16], 8'h77);
    spi_start();
    cmd(1'b0, 7'd1);
    rd_data("recover_rd_w1");
    rd_data("recover_rd_w2");
    spi_end();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
